sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 104 ++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Purpose  : Per-bit switch debouncer. Each raw switch passes through a
//             two-flop synchronizer. A per-bit counter then requires
//             STABLE_CYCLES consecutive mismatching samples before the
//             debounced level is updated. Each bit also carries a sticky
//             change flag, and a one-cycle change pulse covers all bits.
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH         = 18,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             ACLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] SW,
    input  logic [WIDTH-1:0] CLR,
    output logic [WIDTH-1:0] SW_DB,
    output logic             SW_CHG,
    output logic [WIDTH-1:0] SW_EDGE
);

    // The counter only has to reach STABLE_CYCLES-1. The update fires on the
    // next mismatching sample, so it never holds STABLE_CYCLES itself.
    localparam int            CW        = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] c_CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] sw_db_q;
    logic [WIDTH-1:0] sw_db_d;
    logic [WIDTH-1:0] sw_edge_q;
    logic [WIDTH-1:0] sw_edge_d;
    logic             sw_chg_q;
    logic             sw_chg_d;
    logic [WIDTH-1:0] w_upd;

    // Two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
        end
    end

    // Independent stability counter per switch bit
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          w_mis;

            assign w_mis    = sync2_q[i] ^ sw_db_q[i];
            assign w_upd[i] = w_mis && (cnt_q == c_CNT_MAX);

            // Count mismatching samples and restart on any match or on acceptance
            always_comb begin
                cnt_d = '0;
                if (w_mis && (cnt_q != c_CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Counter state, which a reset discards
            always_ff @(posedge ACLK) begin
                if (RESET) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Next-state logic. Set beats clear on the sticky flags.
    always_comb begin
        sw_db_d   = sw_db_q ^ w_upd;
        sw_edge_d = w_upd | (sw_edge_q & ~CLR);
        sw_chg_d  = |w_upd;
    end

    // Registered outputs. Reset takes priority over CLR and over pending updates.
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            sw_db_q   <= '0;
            sw_edge_q <= '0;
            sw_chg_q  <= 1'b0;
        end else begin
            sw_db_q   <= sw_db_d;
            sw_edge_q <= sw_edge_d;
            sw_chg_q  <= sw_chg_d;
        end
    end

    assign SW_DB   = sw_db_q;
    assign SW_EDGE = sw_edge_q;
    assign SW_CHG  = sw_chg_q;

endmodule
`default_nettype wire
